// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

  localparam int unsigned TT_W  = 8;
  localparam int unsigned VEC_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Bits set where the measured table disagrees with the expected code.
  function automatic logic [TT_W-1:0] tt_compare(input logic [TT_W-1:0] meas,
                                                 input logic [TT_W-1:0] exp_code);
    return meas ^ exp_code;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-window counter; tc is high during the last cycle of each window.
module sweep_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap at the terminal count so consecutive windows abut.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (run && tc)) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // tc is registered from the next count, so it lines up with cnt_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc    <= (LAST == '0);
    end else begin
      cnt_q <= cnt_d;
      tc    <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through all eight vectors and captures its truth table.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned     SETTLE_CYCLES = 4,
  parameter logic [TT_W-1:0] EXPECTED      = 8'hF3,
  parameter int unsigned     CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] table_out,
  output logic            match,
  output logic [TT_W-1:0] err_mask
);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [TT_W-1:0]   table_q, table_d;
  logic [TT_W-1:0]   err_q, err_d;
  logic              match_q, match_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tc;

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == SETTLE),
    .clear ((state_q == IDLE) || abort),
    .tc    (tc)
  );

  // Next-state and capture logic; vec returns to 0 whenever a sweep ends.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    table_d = table_q;
    err_d   = err_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          vec_d   = '0;
          busy_d  = 1'b1;
          table_d = '0;
          err_d   = '0;
          match_d = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
          match_d = 1'b0;
        end else if (tc) begin
          table_d[vec_q] = dut_out;
          if (vec_q == VEC_W'(TT_W - 1)) begin
            state_d = IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = tt_compare(table_d, EXPECTED);
            match_d = (err_d == '0);
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      err_q   <= err_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in1       = vec_q[2];
  assign in2       = vec_q[1];
  assign in3       = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign match     = match_q;
  assign err_mask  = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 4-cycle and a 1-cycle settle instance share stimulus.
module tb_truth_table_sweeper;

  localparam logic [7:0] EXP = 8'hF3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] gate  = 8'hF3;
  logic       cmp_en = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       a_in1, a_in2, a_in3, a_out, a_busy, a_done, a_match;
  logic       b_in1, b_in2, b_in3, b_out, b_busy, b_done, b_match;
  logic [7:0] a_tbl, a_err, b_tbl, b_err;

  logic [2:0] d_vec[2];
  logic       d_busy[2], d_done[2], d_match[2];
  logic [7:0] d_tbl[2], d_err[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign a_out = gate[{a_in1, a_in2, a_in3}];
  assign b_out = gate[{b_in1, b_in2, b_in3}];

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(EXP), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .dut_out(a_out),
    .busy(a_busy), .done(a_done), .table_out(a_tbl), .match(a_match), .err_mask(a_err)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(EXP), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .dut_out(b_out),
    .busy(b_busy), .done(b_done), .table_out(b_tbl), .match(b_match), .err_mask(b_err)
  );

  assign d_vec[0] = {a_in1, a_in2, a_in3};
  assign d_vec[1] = {b_in1, b_in2, b_in3};
  assign d_busy[0] = a_busy;   assign d_busy[1] = b_busy;
  assign d_done[0] = a_done;   assign d_done[1] = b_done;
  assign d_match[0] = a_match; assign d_match[1] = b_match;
  assign d_tbl[0] = a_tbl;     assign d_tbl[1] = b_tbl;
  assign d_err[0] = a_err;     assign d_err[1] = b_err;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d] at cyc %0d: actual=%0h required=%0h", nm, inst, cyc, act, req);
    end
  endtask

  // Model: a sweep is an elapsed-edge count; vector k is read from the gate
  // when elapsed reaches (k+1)*S, and the inputs show elapsed/S meanwhile.
  int         m_s[2] = '{4, 1};
  int         m_el[2];
  logic       m_busy[2], m_done[2], m_match[2];
  logic [7:0] m_tbl[2], m_err[2];

  always @(posedge clk) begin : model
    logic       bsy, dn, mt;
    logic [7:0] tb, er;
    int         el, k;
    for (int i = 0; i < 2; i++) begin
      bsy = m_busy[i]; tb = m_tbl[i]; er = m_err[i]; mt = m_match[i]; el = m_el[i];
      dn  = 1'b0;
      if (!rst_n) begin
        bsy = 1'b0; tb = '0; er = '0; mt = 1'b0; el = 0;
      end else if (!bsy) begin
        if (start) begin
          bsy = 1'b1; el = 0; tb = '0; er = '0; mt = 1'b0;
        end
      end else if (abort) begin
        bsy = 1'b0; mt = 1'b0; el = 0;
      end else begin
        el = el + 1;
        if (el % m_s[i] == 0) begin
          k = el / m_s[i] - 1;
          tb[k] = gate[k];
          if (k == 7) begin
            bsy = 1'b0; dn = 1'b1; er = tb ^ EXP; mt = (tb == EXP); el = 0;
          end
        end
      end
      m_busy[i] <= bsy; m_done[i] <= dn; m_tbl[i] <= tb;
      m_err[i]  <= er;  m_match[i] <= mt; m_el[i] <= el;
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0] ev;
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        ev = m_busy[i] ? 3'(m_el[i] / m_s[i]) : 3'd0;
        chk("inputs", i, 32'(d_vec[i]), 32'(ev));
        chk("busy",   i, 32'(d_busy[i]), 32'(m_busy[i]));
        chk("done",   i, 32'(d_done[i]), 32'(m_done[i]));
        chk("table",  i, 32'(d_tbl[i]),  32'(m_tbl[i]));
        chk("match",  i, 32'(d_match[i]), 32'(m_match[i]));
        chk("err",    i, 32'(d_err[i]),  32'(m_err[i]));
      end
    end
  end

  int e;
  int dcnt[2];
  int dat[2];

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset held with start high: nothing may start.
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; gate = 8'hF3;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(d_busy[i]), 32'd0);
      chk("rst_done", i, 32'(d_done[i]), 32'd0);
      chk("rst_inputs", i, 32'(d_vec[i]), 32'd0);
      chk("rst_table", i, 32'(d_tbl[i]), 32'd0);
      chk("rst_match", i, 32'(d_match[i]), 32'd0);
      chk("rst_err", i, 32'(d_err[i]), 32'd0);
    end
    rst_n = 1'b1; start = 1'b0;
    cmp_en = 1'b1;

    // Matching sweep with the 0xF3 gate.
    pulse_start();
    chk("f3_busy_first", 0, 32'(a_busy), 32'd1);
    dcnt = '{0, 0}; dat = '{0, 0};
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (d_done[i] === 1'b1) begin dcnt[i]++; dat[i] = cyc - e; end
      if (cyc == e + 3) chk("s1_inputs_e3", 1, 32'(d_vec[1]), 32'd3);
      if (cyc == e + 5) chk("s4_inputs_e5", 0, 32'(d_vec[0]), 32'd1);
      if (cyc == e + 32) begin
        chk("f3_table", 0, 32'(a_tbl), 32'hF3);
        chk("f3_match", 0, 32'(a_match), 32'd1);
        chk("f3_err", 0, 32'(a_err), 32'h00);
      end
    end
    chk("f3_done_count", 0, 32'(dcnt[0]), 32'd1);
    chk("f3_done_edge", 0, 32'(dat[0]), 32'd32);
    chk("f3_done_count", 1, 32'(dcnt[1]), 32'd1);
    chk("f3_done_edge", 1, 32'(dat[1]), 32'd8);
    chk("f3_table", 1, 32'(b_tbl), 32'hF3);

    // XOR3 gate: mismatch against the expected code.
    gate = 8'h96;
    pulse_start();
    repeat (40) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("x3_table", i, 32'(d_tbl[i]), 32'h96);
      chk("x3_match", i, 32'(d_match[i]), 32'd0);
      chk("x3_err", i, 32'(d_err[i]), 32'h65);
    end

    // Abort after vectors 0 and 1 have been captured.
    gate = 8'hF3;
    pulse_start();
    for (int t = 0; t < 20 && cyc < e + 9; t++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_cycle", 0, 32'(cyc - e), 32'd10);
    chk("ab_busy", 0, 32'(a_busy), 32'd0);
    chk("ab_table", 0, 32'(a_tbl), 32'h03);
    chk("ab_inputs", 0, 32'(d_vec[0]), 32'd0);
    chk("ab_match", 0, 32'(a_match), 32'd0);
    dcnt[0] = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (a_done === 1'b1) dcnt[0]++;
    end
    chk("ab_no_done", 0, 32'(dcnt[0]), 32'd0);
    chk("ab_table_hold", 0, 32'(a_tbl), 32'h03);

    // start held high: ignored while busy, re-accepted in the done cycle.
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    dcnt[0] = 0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (cyc < e + 32 && a_done === 1'b1) dcnt[0]++;
      if (cyc == e + 32) begin
        chk("hold_done", 0, 32'(a_done), 32'd1);
        chk("hold_table", 0, 32'(a_tbl), 32'hF3);
      end
      if (cyc == e + 33) begin
        chk("hold_restart_table", 0, 32'(a_tbl), 32'h00);
        chk("hold_restart_busy", 0, 32'(a_busy), 32'd1);
        chk("hold_restart_done", 0, 32'(a_done), 32'd0);
      end
    end
    chk("hold_early_done", 0, 32'(dcnt[0]), 32'd0);
    start = 1'b0;

    // Reset mid-sweep discards progress.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 0, 32'(a_busy), 32'd0);
    chk("midrst_table", 0, 32'(a_tbl), 32'd0);
    chk("midrst_inputs", 0, 32'(d_vec[0]), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Characterisation stage that drives the three inputs of a 3-input combinational logic gate, e.g. the 0xF3 gate.
- Steps the inputs through all eight input combinations, waits a programmable settle time, then samples the gate output.
- Assembles the measured 8-bit truth table and compares it with an expected code.
- Sits directly upstream (stimulus) and downstream (capture) of a single gate under test.

Parameters:
- SETTLE_CYCLES, 4: cycles each input vector is held before the output is sampled; legal range is 1 to 255.
- EXPECTED, 8'hF3: expected truth table; bit k is the gate output for the input vector {in1,in2,in3} = k.
- CNT_W, 8: width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  requests a sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- in1  output  1  gate input MSB, registered.
- in2  output  1  gate input, registered.
- in3  output  1  gate input LSB, registered.
- dut_out  input  1  gate output, sampled at the end of each settle window.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  measured truth table.
- match  output  1  high when table_out == EXPECTED; valid from done onward.
- err_mask  output  8  table_out XOR EXPECTED.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE; vec = 0; cnt = 0.
  - in1/in2/in3 = 0; busy = 0; done = 0; table_out = 0; match = 0; err_mask = 0.
  - Reset mid-sweep discards all progress.
- States are IDLE and SETTLE; done is a registered pulse, not a separate state.
- IDLE:
  - {in1,in2,in3} = 3'b000.
  - On start=1: go to SETTLE; vec=0; cnt=0; busy=1; table_out=0; match=0; err_mask=0.
- SETTLE:
  - {in1,in2,in3} = vec.
  - Each cycle, cnt increments.
  - When cnt == SETTLE_CYCLES-1, on that edge: table_out[vec] = dut_out; cnt = 0.
    - If vec == 7: state = IDLE; busy = 0; done = 1; match and err_mask are computed from the final table (including the bit just sampled).
    - Otherwise vec = vec + 1; no wrap inside a sweep.
- Timing:
  - If start is sampled at edge E, vector k is sampled at edge E + (k+1)*SETTLE_CYCLES.
  - done is high for exactly one cycle after edge E + 8*SETTLE_CYCLES (32 cycles with the default).
  - SETTLE_CYCLES=1 samples a new vector every cycle.
- start while busy: ignored.
- start in the cycle done is high: accepted, because the block is already in IDLE. The new sweep clears table_out/match/err_mask at its first edge.
- abort=1 in SETTLE:
  - Next edge: state = IDLE; busy = 0; inputs = 0; no done.
  - table_out keeps its partial contents; match = 0.
- abort in IDLE: no effect.
- abort and start both high in IDLE: start wins.
- After done, table_out/match/err_mask hold until the next start or reset.
- dut_out is assumed synchronous to clk; there is no synchroniser inside the block.

Decomposition:
- Shared package tt_pkg:
  - state enum {IDLE, SETTLE}.
  - TT_W=8, VEC_W=3.
  - Function tt_compare(meas, exp) returning err_mask.
- One sub-module, sweep_settle_timer: the parameterised cnt register with terminal-count output tc. The FSM, vec and table logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, inputs 000, busy=0.
- Sweep against a behavioural 0xF3 gate, SETTLE_CYCLES=4, start at edge E:
  - inputs step 000..111, each held 4 cycles.
  - done is high for exactly one cycle after edge E+32.
  - table_out=8'hF3, match=1, err_mask=8'h00.
- Sweep against a 0x96 (XOR3) gate -> table_out=8'h96, match=0, err_mask=8'h65.
- Abort after vectors 0 and 1 are sampled (gate 0xF3):
  - busy=0 next cycle, no done.
  - table_out=8'h03, inputs=000.
- start held high continuously:
  - pulses while busy are ignored.
  - a new sweep begins in the done cycle and table_out reads 0 on the next cycle.
- SETTLE_CYCLES=1 against a 0xF3 gate:
  - done is high for one cycle after edge E+8.
  - table_out=8'hF3.
  - inputs change every cycle.
